// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator divider front-end.
package calc_pkg;

  localparam int CALC_W = 8;

  // Quotient reported for a divide-by-zero request (all ones at CALC_W).
  localparam logic [CALC_W-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    BUSY,
    FIXUP,
    RESP
  } div_seq_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational conditional two's-complement negate; doubles as abs when
// negate is driven by the operand's sign bit.
module div_sign_fix
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  logic signed [W-1:0] value_s;
  logic signed [W-1:0] negated_s;

  assign value_s   = $signed(value);
  assign negated_s = (~value_s) + W'(1);
  assign result    = negate ? $unsigned(negated_s) : value;

endmodule

// File: rtl/div_sequencer.sv
// Request/response sequencer around the shift/add-subtract divider.
// Optional signed support is built when DIV_SIGNED_EN is defined.
module div_sequencer
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [W-1:0] Dividend,
  input  logic [W-1:0] Divisor,
  input  logic         SignedOp,
  output logic         DivStart,
  input  logic         DivDone,
  output logic [W-1:0] DivA,
  output logic [W-1:0] DivB,
  input  logic [W-1:0] DivQ,
  input  logic [W-1:0] DivR,
  output logic         RspValid,
  input  logic         RspReady,
  output logic [W-1:0] Quotient,
  output logic [W-1:0] Remainder,
  output logic         DivByZero
);

  div_seq_state_t state, state_next;

  logic         accept;
  logic         divisor_zero;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W-1:0] raw_q;
  logic [W-1:0] raw_r;
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;

  assign accept       = ReqValid & ReqReady;
  assign divisor_zero = (Divisor == '0);

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_quot;
  logic neg_rem;

  assign a_neg = SignedOp & Dividend[W-1];
  assign b_neg = SignedOp & Divisor[W-1];

  div_sign_fix #(.W(W)) u_abs_a (.value(Dividend), .negate(a_neg), .result(a_mag));
  div_sign_fix #(.W(W)) u_abs_b (.value(Divisor),  .negate(b_neg), .result(b_mag));
  div_sign_fix #(.W(W)) u_fix_q (.value(raw_q), .negate(neg_quot), .result(q_fix));
  div_sign_fix #(.W(W)) u_fix_r (.value(raw_r), .negate(neg_rem),  .result(r_fix));

  // Truncating division: quotient sign from the XOR, remainder follows the dividend.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if ((state == IDLE) && accept) begin
      neg_quot <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = SignedOp;
  assign a_mag            = Dividend;
  assign b_mag            = Divisor;
  assign q_fix            = raw_q;
  assign r_fix            = raw_r;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      DivA      <= '0;
      DivB      <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && accept) begin
        if (divisor_zero) begin
          Quotient  <= {W{DIV0_QUOTIENT[0]}};
          Remainder <= Dividend;
          DivByZero <= 1'b1;
        end else begin
          DivA      <= a_mag;
          DivB      <= b_mag;
          DivByZero <= 1'b0;
        end
      end
      if (state == FIXUP) begin
        Quotient  <= q_fix;
        Remainder <= r_fix;
      end
    end
  end

  // Raw divider results are pure data and need no reset.
  always_ff @(posedge Clock) begin
    if ((state == BUSY) && DivDone) begin
      raw_q <= DivQ;
      raw_r <= DivR;
    end
  end

  always_comb begin
    state_next = state;
    ReqReady   = 1'b0;
    DivStart   = 1'b0;
    RspValid   = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = DivDone;
        if (ReqValid && DivDone) begin
          state_next = divisor_zero ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        DivStart   = 1'b1;
        state_next = ARM;
      end
      // A stale done level from the previous run must not count as completion.
      ARM: begin
        if (!DivDone) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (DivDone) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = RESP;
      end
      RESP: begin
        RspValid = 1'b1;
        if (RspReady) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural multi-cycle divider model.
module tb_div_sequencer;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         ReqValid = 1'b0;
  logic         SignedOp = 1'b0;
  logic         RspReady = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         ReqReady;
  logic         DivStart;
  logic         RspValid;
  logic         DivByZero;
  logic [W-1:0] DivA;
  logic [W-1:0] DivB;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         DivDone = 1'b1;
  logic [W-1:0] DivQ = '0;
  logic [W-1:0] DivR = '0;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] E1Q = 8'hF2, E1R = 8'hFE, E1A = 8'd100;
  localparam logic [W-1:0] E2Q = 8'hF2, E2R = 8'h02;
  localparam logic [W-1:0] E3Q = 8'h80, E3R = 8'h00;
`else
  localparam logic [W-1:0] E1Q = 8'd22, E1R = 8'd2, E1A = 8'h9C;
  localparam logic [W-1:0] E2Q = 8'd0, E2R = 8'd100;
  localparam logic [W-1:0] E3Q = 8'd0, E3R = 8'd128;
`endif

  always #5 Clock = ~Clock;

  div_sequencer #(.W(W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Dividend(Dividend), .Divisor(Divisor), .SignedOp(SignedOp),
    .DivStart(DivStart), .DivDone(DivDone),
    .DivA(DivA), .DivB(DivB), .DivQ(DivQ), .DivR(DivR),
    .RspValid(RspValid), .RspReady(RspReady),
    .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
  );

  always @(posedge Clock) begin
    if (DivStart) start_cnt++;
  end

  // Divider model: no reset; done drops two edges after start, returns 9 edges later.
  int m_state = 0;
  int m_cnt = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = 8'd1;
  always @(posedge Clock) begin
    case (m_state)
      0: if (DivStart) begin ma <= DivA; mb <= DivB; m_state <= 1; end
      1: begin DivDone <= 1'b0; m_cnt <= 8; m_state <= 2; end
      default: begin
        if (m_cnt == 0) begin
          DivDone <= 1'b1;
          DivQ    <= (mb == 0) ? '1 : ma / mb;
          DivR    <= (mb == 0) ? ma : ma % mb;
          m_state <= 0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    endcase
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    while (!ReqReady && n < 200) begin tick(); n++; end
    total++;
    if (ReqReady !== 1'b1) begin
      bad++;
      $display("FAIL send_ready_timeout: got ReqReady=%b want 1", ReqReady);
    end
    ReqValid = 1'b1; Dividend = a; Divisor = b; SignedOp = s;
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic wait_rsp(output int n, output int gap);
    int  done_at = -1;
    bit  seen_low = 0;
    n = 0;
    while (!RspValid && n < 200) begin
      if (!DivDone) seen_low = 1;
      else if (seen_low && done_at < 0) done_at = n;
      tick();
      n++;
    end
    gap = (done_at < 0) ? -1 : n - done_at;
  endtask

  task automatic release_rsp();
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    tick(); tick();
    total++;
    if ({RspValid, DivStart, DivByZero} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000", {RspValid, DivStart, DivByZero});
    end
    total++;
    if ({Quotient, Remainder, DivA, DivB} !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {Quotient, Remainder, DivA, DivB});
    end
    total++;
    if (ReqReady !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", ReqReady);
    end
    Resetn = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    int s0, n, gap;
    s0 = start_cnt;
    send(8'd100, 8'd7, 1'b0);
    total++;
    if ({DivStart, DivA, DivB} !== {1'b1, 8'd100, 8'd7}) begin
      bad++; $display("FAIL u_launch: got start=%b a=%0d b=%0d want 1 100 7", DivStart, DivA, DivB);
    end
    wait_rsp(n, gap);
    total++;
    if (gap !== 2) begin
      bad++; $display("FAIL u_latency: got %0d want 2", gap);
    end
    total++;
    if ({RspValid, Quotient, Remainder, DivByZero} !== {1'b1, 8'd14, 8'd2, 1'b0}) begin
      bad++; $display("FAIL u_result: got v=%b q=%0d r=%0d z=%b want 1 14 2 0", RspValid, Quotient, Remainder, DivByZero);
    end
    total++;
    if (start_cnt - s0 !== 1) begin
      bad++; $display("FAIL u_start_count: got %0d want 1", start_cnt - s0);
    end
    release_rsp();
    send(8'h9C, 8'h07, 1'b0);
    wait_rsp(n, gap);
    total++;
    if ({Quotient, Remainder} !== {8'd22, 8'd2}) begin
      bad++; $display("FAIL u_156_7: got q=%0d r=%0d want 22 2", Quotient, Remainder);
    end
    release_rsp();
  endtask

  task automatic test_signed();
    int n, gap;
    send(8'h9C, 8'h07, 1'b1);
    total++;
    if (DivA !== E1A) begin
      bad++; $display("FAIL s_mag_a: got %h want %h", DivA, E1A);
    end
    wait_rsp(n, gap);
    total++;
    if ({Quotient, Remainder} !== {E1Q, E1R}) begin
      bad++; $display("FAIL s_neg100_7: got q=%h r=%h want %h %h", Quotient, Remainder, E1Q, E1R);
    end
    release_rsp();
    send(8'd100, 8'hF9, 1'b1);
    wait_rsp(n, gap);
    total++;
    if ({Quotient, Remainder} !== {E2Q, E2R}) begin
      bad++; $display("FAIL s_100_neg7: got q=%h r=%h want %h %h", Quotient, Remainder, E2Q, E2R);
    end
    release_rsp();
    send(8'h80, 8'hFF, 1'b1);
    wait_rsp(n, gap);
    total++;
    if ({Quotient, Remainder, DivByZero} !== {E3Q, E3R, 1'b0}) begin
      bad++; $display("FAIL s_minneg: got q=%h r=%h z=%b want %h %h 0", Quotient, Remainder, DivByZero, E3Q, E3R);
    end
    release_rsp();
  endtask

  task automatic test_div_zero();
    int s0, n, gap;
    s0 = start_cnt;
    send(8'd37, 8'd0, 1'b0);
    wait_rsp(n, gap);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL z_latency: got %0d want 0", n);
    end
    total++;
    if ({RspValid, Quotient, Remainder, DivByZero} !== {1'b1, 8'hFF, 8'd37, 1'b1}) begin
      bad++; $display("FAIL z_result: got v=%b q=%h r=%0d z=%b want 1 ff 37 1", RspValid, Quotient, Remainder, DivByZero);
    end
    release_rsp();
    send(8'h80, 8'd0, 1'b1);
    wait_rsp(n, gap);
    total++;
    if ({Quotient, Remainder, DivByZero} !== {8'hFF, 8'h80, 1'b1}) begin
      bad++; $display("FAIL z_signed: got q=%h r=%h z=%b want ff 80 1", Quotient, Remainder, DivByZero);
    end
    total++;
    if (start_cnt - s0 !== 0) begin
      bad++; $display("FAIL z_no_start: got %0d want 0", start_cnt - s0);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    int n, gap;
    send(8'd50, 8'd6, 1'b0);
    wait_rsp(n, gap);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({RspValid, ReqReady, Quotient, Remainder, DivByZero} !== {1'b1, 1'b0, 8'd8, 8'd2, 1'b0}) begin
        bad++; $display("FAIL hold_%0d: got v=%b rdy=%b q=%0d r=%0d z=%b want 1 0 8 2 0", i, RspValid, ReqReady, Quotient, Remainder, DivByZero);
      end
    end
    release_rsp();
    total++;
    if ({RspValid, ReqReady} !== 2'b01) begin
      bad++; $display("FAIL hold_release: got v=%b rdy=%b want 0 1", RspValid, ReqReady);
    end
    send(8'd9, 8'd4, 1'b0);
    total++;
    if (DivStart !== 1'b1) begin
      bad++; $display("FAIL b2b_accept: got start=%b want 1", DivStart);
    end
    wait_rsp(n, gap);
    total++;
    if ({Quotient, Remainder} !== {8'd2, 8'd1}) begin
      bad++; $display("FAIL b2b_result: got q=%0d r=%0d want 2 1", Quotient, Remainder);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    int s0, n, gap, viol;
    send(8'd200, 8'd3, 1'b0);
    n = 0;
    while (DivDone && n < 50) begin tick(); n++; end
    tick(); tick();
    #2 Resetn = 1'b0;
    #1;
    total++;
    if ({RspValid, DivStart, DivByZero, ReqReady} !== 4'b0000) begin
      bad++; $display("FAIL rst_mid_ctrl: got %b want 0000", {RspValid, DivStart, DivByZero, ReqReady});
    end
    total++;
    if ({Quotient, Remainder, DivA, DivB} !== 32'h0) begin
      bad++; $display("FAIL rst_mid_data: got %h want 0", {Quotient, Remainder, DivA, DivB});
    end
    #1 Resetn = 1'b1;
    s0 = start_cnt;
    viol = 0;
    n = 0;
    while (!DivDone && n < 50) begin
      if (DivStart || ReqReady) viol++;
      tick();
      n++;
    end
    total++;
    if (viol !== 0 || start_cnt != s0) begin
      bad++; $display("FAIL rst_mid_quiet: got viol=%0d starts=%0d want 0 0", viol, start_cnt - s0);
    end
    send(8'd90, 8'd9, 1'b0);
    wait_rsp(n, gap);
    total++;
    if ({RspValid, Quotient, Remainder} !== {1'b1, 8'd10, 8'd0}) begin
      bad++; $display("FAIL rst_mid_next: got v=%b q=%0d r=%0d want 1 10 0", RspValid, Quotient, Remainder);
    end
    release_rsp();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Front-end sequencer for the calculator's shift/add-subtract divider. It accepts a dividend/divisor request over a valid/ready handshake and screens out divide-by-zero. It converts signed operands to magnitudes, pulses the divider controller's start input, and waits for its done flag. It then captures quotient and remainder, restores signs, and holds the result on a valid/ready response port until the consumer takes it.

## Interface
- `W`, default 8: operand/result width; must match the divider datapath (8 iterations).
- `Clock`, in, 1: active-high clock.
- `Resetn`, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `ReqValid`, in, 1: request present.
- `ReqReady`, out, 1: sequencer can accept a request.
- `Dividend`, in, W: two's-complement or unsigned dividend.
- `Divisor`, in, W: two's-complement or unsigned divisor.
- `SignedOp`, in, 1: 1 = signed division.
- `DivStart`, out, 1: one-cycle start pulse to the divider controller.
- `DivDone`, in, 1: divider done flag; level, high while the divider is idle.
- `DivA`, out, W: magnitude dividend to the divider Q register.
- `DivB`, out, W: magnitude divisor to the divider D register.
- `DivQ`, in, W: divider quotient.
- `DivR`, in, W: divider remainder.
- `RspValid`, out, 1: result valid.
- `RspReady`, in, 1: consumer accepts result.
- `Quotient`, out, W: signed-corrected quotient.
- `Remainder`, out, W: signed-corrected remainder.
- `DivByZero`, out, 1: result is the divide-by-zero response.

## Operation
- States: IDLE, LAUNCH, ARM, BUSY, FIXUP, RESP.
- IDLE:
  - `ReqReady` = `DivDone`.
  - On `ReqValid & ReqReady`, latch the operands and the sign flags.
  - Divisor == 0 → RESP with `Quotient` = all ones, `Remainder` = Dividend, `DivByZero` = 1. `DivStart` is never asserted.
  - Otherwise → LAUNCH.
- LAUNCH: `DivStart` = 1 for exactly one cycle; `DivA`/`DivB` driven with magnitudes → ARM.
- ARM: wait for `DivDone` = 0, i.e. the divider has left its end state → BUSY.
- BUSY: wait for `DivDone` = 1; capture `DivQ`/`DivR` → FIXUP.
- FIXUP: apply the sign rules → RESP.
- RESP: `RspValid` = 1. `Quotient`, `Remainder` and `DivByZero` are held stable until `RspValid & RspReady`, then → IDLE.
- `DivA`/`DivB` are held from LAUNCH through BUSY.
- Sign rules for a signed op:
  - Magnitude = two's-complement abs.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
  - Most-negative / −1 needs no special path: the magnitude 2^(W−1) fits unsigned, and negation yields `Quotient` = 2^(W−1), `Remainder` = 0.
- Unsigned op: operands pass straight through; no fixup.
- Only one request is in flight; `ReqReady` = 0 in every state except IDLE.

## Timing
- Reset values: state IDLE; `ReqReady` = `DivDone` (combinational); `DivStart` = 0, `RspValid` = 0, `Quotient` = 0, `Remainder` = 0, `DivByZero` = 0, `DivA` = 0, `DivB` = 0.
- Non-zero divisor: `DivStart` is high in the cycle after acceptance. `RspValid` rises 2 cycles after the first cycle in which BUSY sees `DivDone` = 1.
- Divide-by-zero: `RspValid` is high in the cycle after acceptance.
- Back-to-back: a new request can be accepted in the cycle after the response handshake.
- Reset mid-operation: the sequencer returns to IDLE immediately. The divider has no reset, so `ReqReady` stays low until `DivDone` reads 1; no start is issued while the divider is busy.
- `DivDone` already high in ARM: wait, never BUSY early. ARM and BUSY have no timeout.

## Configuration
- `DIV_SIGNED_EN` defined: `SignedOp` is honoured; the abs/negate logic and FIXUP sign handling are built.
- `DIV_SIGNED_EN` undefined: `SignedOp` is ignored and all operations are unsigned. FIXUP remains as a pass-through cycle so latency is identical.

## Structure
- Package `calc_pkg` holds:
  - the `div_seq_state_t` enum;
  - the default width `CALC_W` = 8;
  - the divide-by-zero quotient constant (all ones).
- Sub-module `div_sign_fix`: combinational two's-complement abs and conditional negate. It is instantiated for the operand magnitudes and the result fixup.

## Test plan
- Unsigned 100 / 7 → `DivStart` pulse once, `Quotient` = 14, `Remainder` = 2, `DivByZero` = 0.
- Signed −100 / 7 (0x9C / 0x07) → `Quotient` = 0xF2 (−14), `Remainder` = 0xFE (−2); 100 / −7 → `Quotient` = 0xF2, `Remainder` = 0x02.
- Signed 0x80 / 0xFF → `Quotient` = 0x80, `Remainder` = 0x00; with `DIV_SIGNED_EN` off, 128 / 255 → `Quotient` = 0, `Remainder` = 128.
- 37 / 0 → `RspValid` the cycle after acceptance, `Quotient` = 0xFF, `Remainder` = 37, `DivByZero` = 1, no `DivStart`.
- Hold `RspReady` low for 5 cycles → outputs stable, `ReqReady` = 0; release → accepted, IDLE next cycle.
- Assert `Resetn` low during BUSY → all outputs 0 at once. After release, no `DivStart` until `DivDone` = 1, and the next request completes correctly.
